hex_keypad_scanner: RTL and testbench

//  Input-side counterpart of the 7-segment display driver. Scans a 4x4 hex keypad
//  (active-low rows/cols), debounces presses, and shifts each accepted hex key into
//  a 16-bit value that feeds the display driver's digit input directly.
//  One key is accepted per press; holding a key produces no auto-repeat.

---
 rtl/hex_keypad_scanner.sv | 101 ++++++++++
 tb/tb_hex_keypad_scanner.sv | 133 +++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 active-low keypad, debounces presses and shifts accepted keys into digit
// Ports: clk; rst (async, active-high); row (one-cold row drive); col (pulled-up columns, 0 = closed);
//        clr (sync digit clear); digit (last four keys, newest in [3:0]); key_code ({r,c} of last key);
//        key_valid (one-cycle accept pulse)
module hex_keypad_scanner #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter logic [19:0] DEBOUNCE = 20'd500000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [15:0] digit,
  output logic [3:0]  key_code,
  output logic        key_valid
);
  typedef enum logic [1:0] {SCAN, DEB, HOLD} state_t;
  state_t      state, state_n;
  logic [3:0]  c1, cs, pat, z;
  logic [1:0]  row_sel, row_sel_n, r, c, c_n;
  logic [19:0] cnt, cnt_n;
  logic        one_zero, latch, accept;
  assign z = ~cs;
  // a single closed column in the driven row; multi-key chords are ignored
  assign one_zero = (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
  assign c_n = z[0] ? 2'd0 : z[1] ? 2'd1 : z[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    row_sel_n = row_sel;
    latch     = 1'b0;
    accept    = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == {4'd0, SCAN_DIV - 16'd1}) begin
          cnt_n = '0;
          if (one_zero) begin
            latch   = 1'b1;
            state_n = DEB;
          end else row_sel_n = row_sel + 2'd1;
        end else cnt_n = cnt + 20'd1;
      end
      DEB: begin
        if (cs != pat) begin
          state_n   = SCAN;
          cnt_n     = '0;
          row_sel_n = r + 2'd1;
        end else if (cnt == DEBOUNCE - 20'd1) begin
          accept  = 1'b1;
          state_n = HOLD;
          cnt_n   = '0;
        end else cnt_n = cnt + 20'd1;
      end
      HOLD: begin
        if (cs != 4'hF) cnt_n = '0;
        else if (cnt == DEBOUNCE - 20'd1) begin
          state_n   = SCAN;
          cnt_n     = '0;
          row_sel_n = 2'd0;
        end else cnt_n = cnt + 20'd1;
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      row_sel   <= 2'd0;
      row       <= 4'b1110;
      c1        <= 4'hF;
      cs        <= 4'hF;
      pat       <= 4'hF;
      r         <= 2'd0;
      c         <= 2'd0;
      digit     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      row_sel   <= row_sel_n;
      // row is registered from the next row_sel so it always matches row_sel
      row       <= ~(4'b0001 << row_sel_n);
      c1        <= col;
      cs        <= c1;
      if (latch) begin
        r   <= row_sel;
        c   <= c_n;
        pat <= cs;
      end
      key_valid <= accept;
      if (accept) key_code <= {r, c};
      digit     <= clr ? 16'h0 : accept ? {digit[11:0], r, c} : digit;
    end
  end
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: scoreboard bench for hex_keypad_scanner with a keypad model and random key presses
module tb_hex_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  row, col, key_code;
  logic [15:0] digit;
  logic        key_valid;
  logic [15:0] pressed = '0;
  logic [15:0] mdig = '0;
  logic [19:0] q[$];
  logic [19:0] mon_e;
  logic [3:0]  one = 4'b0001;
  int total = 0;
  int pass_cnt = 0;
  always #5 clk = ~clk;
  hex_keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE(20'd8)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .clr(clr),
    .digit(digit), .key_code(key_code), .key_valid(key_valid)
  );
  always_comb begin
    col = 4'hF;
    for (int cc = 0; cc < 4; cc++)
      for (int rr = 0; rr < 4; rr++)
        if (pressed[rr*4+cc] && !row[rr]) col[cc] = 1'b0;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (q.size() == 0) check("unexpected key_valid", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, mon_e[19:16]});
        check("digit", {16'd0, digit}, {16'd0, mon_e[15:0]});
      end
    end
  end
  task automatic press(input int r, input int c, input int hold, input int gap);
    logic [3:0] code;
    code = 4'(r*4 + c);
    mdig = clr ? 16'h0 : {mdig[11:0], code};
    q.push_back({code, mdig});
    pressed[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = '0;
    repeat (gap) @(negedge clk);
    check("pending accepts", q.size(), 32'd0);
  endtask
  task automatic wait_row(input logic [3:0] w);
    int n;
    n = 0;
    while (row !== w && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("row reached", {28'd0, row}, {28'd0, w});
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset row", {28'd0, row}, 32'h0000000E);
    check("reset digit", {16'd0, digit}, 32'd0);
    check("reset key_code", {28'd0, key_code}, 32'd0);
    check("reset key_valid", {31'd0, key_valid}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("scan row", {28'd0, row}, {28'd0, ~(one << ((k / 4) % 4))});
      @(negedge clk);
    end
    check("idle digit", {16'd0, digit}, 32'd0);
    press(2, 1, 100, 100);
    check("digit after 9", {16'd0, digit}, 32'h0009);
    check("key_code after 9", {28'd0, key_code}, 32'h9);
    press(3, 3, 100, 100);
    check("digit after F", {16'd0, digit}, 32'h009F);
    wait_row(4'b1110);
    wait_row(4'b1101);
    pressed[4] = 1'b1;
    repeat (3) @(negedge clk);
    pressed = '0;
    repeat (4) @(negedge clk);
    check("bounce resumes row 2", {28'd0, row}, 32'h0000000B);
    repeat (40) @(negedge clk);
    check("bounce digit", {16'd0, digit}, {16'd0, mdig});
    press(0, 1, 100, 100);
    press(0, 2, 100, 100);
    press(0, 3, 100, 100);
    press(1, 0, 100, 100);
    press(1, 1, 1000, 100);
    check("digit 2345", {16'd0, digit}, 32'h2345);
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    repeat (100) @(negedge clk);
    pressed = '0;
    repeat (100) @(negedge clk);
    check("chord digit", {16'd0, digit}, 32'h2345);
    clr = 1'b1;
    press(3, 0, 100, 100);
    clr = 1'b0;
    check("clr digit", {16'd0, digit}, 32'd0);
    check("clr key_code", {28'd0, key_code}, 32'hC);
    wait_row(4'b1110);
    wait_row(4'b1011);
    pressed[10] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst row", {28'd0, row}, 32'h0000000E);
    check("rst digit", {16'd0, digit}, 32'd0);
    check("rst key_code", {28'd0, key_code}, 32'd0);
    check("rst key_valid", {31'd0, key_valid}, 32'd0);
    pressed = '0;
    mdig = '0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    press(1, 3, 100, 100);
    check("digit after rst", {16'd0, digit}, 32'h0007);
    for (int i = 0; i < 8; i++)
      press(int'($urandom_range(3)), int'($urandom_range(3)),
            int'($urandom_range(150, 60)), int'($urandom_range(120, 40)));
    check("random digit", {16'd0, digit}, {16'd0, mdig});
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
